// File: rtl/vga_fb_pkg.sv
// Shared VGA 640x480@60 timing constants, clear-FSM state type and colour expansion
// for the framebuffer scanout block.
package vga_fb_pkg;

  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] H_FP    = 10'd16;
  localparam logic [9:0] H_SYNC  = 10'd96;
  localparam logic [9:0] H_BP    = 10'd48;
  localparam logic [9:0] H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam logic [9:0] V_VIS   = 10'd480;
  localparam logic [9:0] V_FP    = 10'd10;
  localparam logic [9:0] V_SYNC  = 10'd2;
  localparam logic [9:0] V_BP    = 10'd33;
  localparam logic [9:0] V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int PIPE_DEPTH = 2;

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  // Replicate a c-bit field (right-aligned in 'field') MSB-first across 8 bits.
  function automatic logic [7:0] expand_chan(input logic [7:0] field, input int c);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[3'(7 - i)] = field[3'(c - 1 - (i % c))];
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical pixel counters with visible-region and active-low sync decode.
module vga_timing
  import vga_fb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       visible,
  output logic       hs,
  output logic       vs
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (hcnt == H_TOTAL - 10'd1) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_TOTAL - 10'd1) ? '0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  assign visible = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign hs = !((hcnt >= H_VIS + H_FP) && (hcnt < H_VIS + H_FP + H_SYNC));
  assign vs = !((vcnt >= V_VIS + V_FP) && (vcnt < V_VIS + V_FP + V_SYNC));

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer with plot write port and 640x480@60 VGA scanout.
// Define VGA_FB_CLEAR_EN to zero the framebuffer after every reset release.
module vga_fb_scanout
  import vga_fb_pkg::*;
#(
  parameter int RES_DIV    = 4,
  parameter int COLOR_BITS = 9
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [9:0]            VGA_X,
  input  logic [8:0]            VGA_Y,
  input  logic [COLOR_BITS-1:0] VGA_COLOR,
  input  logic                  plot,
  output logic [7:0]            VGA_R,
  output logic [7:0]            VGA_G,
  output logic [7:0]            VGA_B,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic                  VGA_BLANK_N,
  output logic                  VGA_SYNC_N,
  output logic                  VGA_CLK,
  output logic                  busy
);

  localparam int FB_W = 640 / RES_DIV;
  localparam int FB_H = 480 / RES_DIV;
  localparam int FB_N = FB_W * FB_H;
  localparam int AW   = $clog2(FB_N);
  localparam int C    = COLOR_BITS / 3;

  logic                  pix_en;
  logic [9:0]            hcnt, vcnt;
  logic                  visible, hs, vs;
  logic [AW-1:0]         raddr, plot_addr, wr_addr;
  logic                  plot_ok, wr_en;
  logic [COLOR_BITS-1:0] wr_data;
  logic [COLOR_BITS-1:0] fb_mem [FB_N];
  logic [COLOR_BITS-1:0] rd_data_p0;
  logic                  vld_p0, hs_p0, vs_p0;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) VGA_CLK <= 1'b0;
    else       VGA_CLK <= ~VGA_CLK;
  end

  assign pix_en     = VGA_CLK;
  assign VGA_SYNC_N = 1'b0;

  vga_timing u_timing (
    .clk     (CLOCK_50),
    .rst     (reset),
    .pix_en  (pix_en),
    .hcnt    (hcnt),
    .vcnt    (vcnt),
    .visible (visible),
    .hs      (hs),
    .vs      (vs)
  );

  assign plot_ok   = plot && (int'(VGA_X) < FB_W) && (int'(VGA_Y) < FB_H);
  assign plot_addr = AW'(VGA_Y) * AW'(FB_W) + AW'(VGA_X);

`ifdef VGA_FB_CLEAR_EN
  clr_state_t    state_q, state_d;
  logic [AW-1:0] clr_addr;

  // Reset lands directly in CLEAR so the sweep starts on the first edge after release.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= CLEAR;
      clr_addr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_addr <= clr_addr + AW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: ;
      CLEAR: begin
        busy = 1'b1;
        if (clr_addr == AW'(FB_N - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en   = busy | plot_ok;
  assign wr_addr = busy ? clr_addr : plot_addr;
  assign wr_data = busy ? '0 : VGA_COLOR;
`else
  assign busy    = 1'b0;
  assign wr_en   = plot_ok;
  assign wr_addr = plot_addr;
  assign wr_data = VGA_COLOR;
`endif

  // Stage 1: scan address from the live counters
  assign raddr = visible ? AW'(int'(vcnt) / RES_DIV) * AW'(FB_W) + AW'(int'(hcnt) / RES_DIV)
                         : '0;

  // Stage 2: synchronous RAM read; a same-edge write is not seen by the read
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) fb_mem[wr_addr] <= wr_data;
    if (pix_en) rd_data_p0 <= fb_mem[raddr];
  end

  // Stage 3: output registers, syncs delayed to line up with colour
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      vld_p0      <= 1'b0;
      hs_p0       <= 1'b1;
      vs_p0       <= 1'b1;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pix_en) begin
      vld_p0      <= visible;
      hs_p0       <= hs;
      vs_p0       <= vs;
      VGA_HS      <= hs_p0;
      VGA_VS      <= vs_p0;
      VGA_BLANK_N <= vld_p0;
      VGA_R <= vld_p0 ? expand_chan(8'(rd_data_p0[COLOR_BITS-1 -: C]), C) : 8'd0;
      VGA_G <= vld_p0 ? expand_chan(8'(rd_data_p0[2*C-1 -: C]), C) : 8'd0;
      VGA_B <= vld_p0 ? expand_chan(8'(rd_data_p0[C-1:0]), C) : 8'd0;
    end
  end

endmodule
